// File: rtl/viterbi_decoder_k4.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=4 code (G1=1111, G0=1101), 8-state ACS with
// register-exchange survivors. Define VITERBI_ERR_CNT_EN to add the err_cnt output.
module viterbi_decoder_k4 #(
  parameter int unsigned TB_DEPTH = 24,
  parameter int unsigned PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
  output logic       out_valid,
  output logic       out_bit
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned FillW = $clog2(TB_DEPTH + 1);

  logic [PM_W-1:0]     pm_q   [8];
  logic [PM_W-1:0]     pm_d   [8];
  logic [PM_W-1:0]     acs    [8];
  logic                sel    [8];
  logic [TB_DEPTH-1:0] surv_q [8];
  logic [TB_DEPTH-1:0] surv_d [8];
  logic [FillW-1:0]    fill_q;
  logic [PM_W-1:0]     pm_min;
  logic [2:0]          best;
  logic                out_valid_q;
  logic                out_bit_q;

  // Encoder output for input bit u leaving state s = {u(n-1), u(n-2), u(n-3)}.
  function automatic logic [1:0] expected_sym(input logic [2:0] s, input logic u);
    return {u ^ s[2] ^ s[1] ^ s[0], u ^ s[2] ^ s[0]};
  endfunction

  function automatic logic [1:0] branch_metric(input logic [1:0] d);
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  for (genvar n = 0; n < 8; n++) begin : g_acs
    localparam logic [2:0] Nxt   = 3'(n);
    localparam logic [2:0] Pred0 = {Nxt[1:0], 1'b0};
    localparam logic [2:0] Pred1 = {Nxt[1:0], 1'b1};

    logic [1:0]    bm0, bm1;
    logic [PM_W:0] sum0, sum1;
    logic [PM_W-1:0] cand0, cand1;

    assign bm0   = branch_metric(in_sym ^ expected_sym(Pred0, Nxt[2]));
    assign bm1   = branch_metric(in_sym ^ expected_sym(Pred1, Nxt[2]));
    assign sum0  = {1'b0, pm_q[Pred0]} + {{(PM_W - 1){1'b0}}, bm0};
    assign sum1  = {1'b0, pm_q[Pred1]} + {{(PM_W - 1){1'b0}}, bm1};
    assign cand0 = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
    assign cand1 = sum1[PM_W] ? '1 : sum1[PM_W-1:0];

    // Strict compare so that a tie keeps the x=0 predecessor.
    assign sel[n]    = cand1 < cand0;
    assign acs[n]    = sel[n] ? cand1 : cand0;
    assign pm_d[n]   = acs[n] - pm_min;
    assign surv_d[n] = sel[n] ? {surv_q[Pred1][TB_DEPTH-2:0], Nxt[2]}
                              : {surv_q[Pred0][TB_DEPTH-2:0], Nxt[2]};
  end

  always_comb begin
    pm_min = acs[0];
    for (int i = 1; i < 8; i++) begin
      if (acs[i] < pm_min) pm_min = acs[i];
    end
  end

  // Descending scan leaves the lowest-index zero-metric state.
  always_comb begin
    best = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pm_q[i] == '0) best = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_W'(8);
        surv_q[i] <= '0;
      end
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      out_valid_q <= in_valid && (fill_q == FillW'(TB_DEPTH));
      if (in_valid) begin
        for (int i = 0; i < 8; i++) begin
          pm_q[i]   <= pm_d[i];
          surv_q[i] <= surv_d[i];
        end
        out_bit_q <= surv_q[best][TB_DEPTH-1];
        if (fill_q != FillW'(TB_DEPTH)) fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;

`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_q;
  logic [16:0] err_sum;

  // The normalization minimum is the best-path metric growth for this step.
  assign err_sum = {1'b0, err_q} + 17'(pm_min);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
    end else if (in_valid) begin
      err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder_k4.sv
// Self-checking bench for viterbi_decoder_k4: directed vector table plus random streams compared
// against an unnormalized traceback Viterbi model and the original information bits.
module tb_viterbi_decoder_k4;

  localparam int TbDepth = 24;
  localparam int PmW     = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_sym = 2'b00;
  logic       out_valid;
  logic       out_bit;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  viterbi_decoder_k4 #(
    .TB_DEPTH(TbDepth),
    .PM_W    (PmW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sym   (in_sym),
    .out_valid(out_valid),
    .out_bit  (out_bit)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unnormalized integer metrics, per-step decision bits, traceback output.
  int         m_pm[8];
  logic [7:0] m_dec[$];
  int         m_err;
  bit         m_bit;

  bit         info_q[$];
  logic [1:0] sym_q[$];
  bit         dec_out[$];

  function automatic logic [1:0] enc_sym(input logic [2:0] s, input bit u);
    return {u ^ s[2] ^ s[1] ^ s[0], u ^ s[2] ^ s[0]};
  endfunction

  function automatic void model_reset();
    m_pm = '{0, 8, 8, 8, 8, 8, 8, 8};
    m_dec.delete();
    m_err = 0;
    m_bit = 1'b0;
  endfunction

  // Returns expected out_valid for this accepted symbol and updates m_bit.
  function automatic bit model_step(input logic [1:0] sym);
    int         np[8];
    logic [7:0] d;
    bit         v;
    int         best;
    int         mn;
    logic [2:0] cur;
    logic [2:0] nb, p0, p1;
    int         c0, c1;
    v = (m_dec.size() >= TbDepth);
    if (v) begin
      best = 0;
      for (int i = 1; i < 8; i++) if (m_pm[i] < m_pm[best]) best = i;
      cur = 3'(best);
      for (int k = m_dec.size() - 1; k >= m_dec.size() - TbDepth; k--) begin
        m_bit = cur[2];
        cur = {cur[1:0], m_dec[k][cur]};
      end
    end
    d = '0;
    for (int n = 0; n < 8; n++) begin
      nb = 3'(n);
      p0 = {nb[1:0], 1'b0};
      p1 = {nb[1:0], 1'b1};
      c0 = m_pm[p0] + $countones(sym ^ enc_sym(p0, nb[2]));
      c1 = m_pm[p1] + $countones(sym ^ enc_sym(p1, nb[2]));
      if (c1 < c0) begin
        np[n] = c1;
        d[n] = 1'b1;
      end else begin
        np[n] = c0;
      end
    end
    mn = np[0];
    for (int n = 0; n < 8; n++) begin
      m_pm[n] = np[n];
      if (np[n] < mn) mn = np[n];
    end
    m_dec.push_back(d);
    m_err = (mn > 65535) ? 65535 : mn;
    return v;
  endfunction

  task automatic drive(input bit v, input logic [1:0] s);
    bit ev;
    in_valid = v;
    in_sym   = s;
    ev = v ? model_step(s) : 1'b0;
    @(posedge clk);
    #1;
    check("out_valid", int'(out_valid), int'(ev));
    check("out_bit", int'(out_bit), int'(m_bit));
`ifdef VITERBI_ERR_CNT_EN
    check("err_cnt", int'(err_cnt), m_err);
`endif
    if (out_valid) dec_out.push_back(out_bit);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_bit", int'(out_bit), 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_valid", int'(out_valid), 0);
`ifdef VITERBI_ERR_CNT_EN
    check("reset_err_cnt", int'(err_cnt), 0);
`endif
    rst = 1'b1;
    model_reset();
    dec_out.delete();
  endtask

  // Random info bits followed by TbDepth zero pad bits, encoded from state 0.
  task automatic build_stream(input int n);
    logic [2:0] st;
    bit u;
    info_q.delete();
    sym_q.delete();
    st = '0;
    for (int i = 0; i < n + TbDepth; i++) begin
      u = (i < n) ? bit'($urandom_range(0, 1)) : 1'b0;
      info_q.push_back(u);
      sym_q.push_back(enc_sym(st, u));
      st = {u, st[2:1]};
    end
  endtask

  task automatic flip(input int idx);
    sym_q[idx] = sym_q[idx] ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
  endtask

  task automatic play_stream(input int n, input bit gaps, input int exp_err, input string tag);
    int mism;
    for (int i = 0; i < sym_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) drive(1'b0, 2'($urandom));
      end
      drive(1'b1, sym_q[i]);
    end
    check({tag, "_len"}, dec_out.size(), n);
    mism = 0;
    for (int k = 0; k < n && k < dec_out.size(); k++) if (dec_out[k] != info_q[k]) mism++;
    check({tag, "_bit_errors"}, mism, 0);
`ifdef VITERBI_ERR_CNT_EN
    check({tag, "_err_cnt"}, int'(err_cnt), exp_err);
`else
    if (exp_err < 0) $display("unexpected error budget %0d", exp_err);
`endif
  endtask

  typedef struct {
    bit         do_rst;
    bit         vld;
    logic [1:0] sym;
    bit         exp_valid;
    bit         exp_bit;
  } vec_t;

  vec_t vecs[85];

  initial begin
    // Segment 0..39: all-zero stream. 40..79: impulse. 80..84: idle with out_bit held.
    for (int i = 0; i < 40; i++) begin
      vecs[i] = '{do_rst: (i == 0), vld: 1'b1, sym: 2'b00, exp_valid: (i >= TbDepth),
                  exp_bit: 1'b0};
      vecs[40 + i] = '{do_rst: (i == 0), vld: 1'b1, sym: 2'b00, exp_valid: (i >= TbDepth),
                       exp_bit: (i == TbDepth)};
    end
    vecs[40].sym = 2'b11;
    vecs[41].sym = 2'b11;
    vecs[42].sym = 2'b10;
    vecs[43].sym = 2'b11;
    for (int i = 80; i < 85; i++) begin
      vecs[i] = '{do_rst: 1'b0, vld: 1'b0, sym: 2'b11, exp_valid: 1'b0, exp_bit: 1'b0};
    end

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_out_valid", int'(out_valid), 0);
    check("init_out_bit", int'(out_bit), 0);
    rst = 1'b1;

    for (int i = 0; i < 85; i++) begin
      if (vecs[i].do_rst) do_reset();
      in_valid = vecs[i].vld;
      in_sym   = vecs[i].sym;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_bit", i), int'(out_bit), int'(vecs[i].exp_bit));
    end
`ifdef VITERBI_ERR_CNT_EN
    check("impulse_err_cnt", int'(err_cnt), 0);
`endif

    // Clean random stream, back-to-back.
    do_reset();
    build_stream(200);
    play_stream(200, 1'b0, 0, "clean");

    // One channel error at symbol 50.
    do_reset();
    build_stream(200);
    flip(50);
    play_stream(200, 1'b0, 1, "one_flip");

    // Two channel errors 50 symbols apart.
    do_reset();
    build_stream(200);
    flip(50);
    flip(100);
    play_stream(200, 1'b0, 2, "two_flip");

    // Random in_valid gaps.
    do_reset();
    build_stream(200);
    play_stream(200, 1'b1, 0, "gaps");

    // Reset asserted mid-stream at symbol 70, then a fresh stream.
    do_reset();
    build_stream(100);
    for (int i = 0; i < 70; i++) drive(1'b1, sym_q[i]);
    check("pre_reset_valid", int'(out_valid), 1);
    do_reset();
    build_stream(150);
    play_stream(150, 1'b0, 0, "after_reset");

    // Pure noise: exercises ties and metric bounds against the model.
    do_reset();
    for (int i = 0; i < 1000; i++) drive(1'b1, 2'($urandom));
    check("noise_outputs", dec_out.size(), 1000 - TbDepth);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder_k4.md
# viterbi_decoder_k4

- Hard-decision Viterbi decoder for the rate-1/2, K=4 convolutional code produced by our K=4 encoder.
- Code generators: G1 = 1111 (octal 17) and G0 = 1101 (octal 15).
- Takes one 2-bit channel symbol per accepted cycle and outputs one decoded bit per accepted cycle, delayed by a fixed decision depth.
- Uses an 8-state add-compare-select (ACS) array, register-exchange survivor memory and per-step path-metric normalization.
- Sits at the receive end of the encoder/decoder chain.

## Interface
Parameters:
- TB_DEPTH, 24: decision depth in symbols. This is the survivor register length. Legal range 8..64.
- PM_W, 6: path-metric width in bits. Minimum 5.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. Only clock domain is clk.
- in_valid  input  1  in_sym is accepted on this edge.
- in_sym  input  2  received symbol. in_sym[1] is the G1 (1111) bit; in_sym[0] is the G0 (1101) bit.
- out_valid  output  1  out_bit is valid this cycle.
- out_bit  output  1  decoded information bit.
- err_cnt  output  16  estimated channel bit errors. Present only with VITERBI_ERR_CNT_EN.

## Operation
State encoding:
- State S[2:0] = {u(n-1), u(n-2), u(n-3)}.
- For input bit u, next state N = {u, S[2], S[1]}.
- Expected symbol = {u^S2^S1^S0, u^S2^S0}.

Per accepted symbol (in_valid=1):
- Branch metric for each transition = popcount(in_sym ^ expected), range 0..2.
- Each N has two predecessors P_x = {N[1], N[0], x}, x in {0,1}.
- Candidate metric = PM[P_x] + BM, saturating at 2^PM_W-1.
- The smaller candidate wins. On a tie, x=0 wins.
- Survivor update: surv[N] <= {surv[P_x][TB_DEPTH-2:0], N[2]}.
- Normalization: the minimum of the 8 new metrics is subtracted from all of them before they are registered, so at least one state always holds 0.
- Best state: lowest-index state with PM = 0, taken from the registered metrics before the update.

Output:
- out_bit <= surv[best][TB_DEPTH-1], evaluated on the same edge as the update.
- A fill counter counts accepted symbols and saturates at TB_DEPTH.
- out_valid <= in_valid && (fill == TB_DEPTH).

When in_valid=0:
- Metrics, survivors and the fill counter hold.
- out_valid <= 0. out_bit holds its value.

There is no trellis termination or flush. The last TB_DEPTH bits of a stream are emitted only if padding symbols follow.

## Timing
Reset (rst=0, asynchronous):
- PM[0]=0; PM[1..7]=8.
- All survivors = 0; fill = 0.
- out_valid=0, out_bit=0, err_cnt=0.
- All values hold while rst=0.
- Reset mid-stream discards all state. Decoding restarts assuming encoder state 0.

Latency:
- Symbol m is accepted on an edge. Its decoded bit appears on out_bit after the edge that accepts symbol m+TB_DEPTH.
- With back-to-back input this is TB_DEPTH+1 edges.
- The first out_valid occurs on the edge accepting the (TB_DEPTH+1)-th symbol.

Gaps and throughput:
- Gaps in in_valid stretch latency by exactly the gap length.
- Decoded order and values are unaffected by gaps.
- Throughput is one symbol per cycle. There is no backpressure.

## Configuration
VITERBI_ERR_CNT_EN:
- Defined: err_cnt is a port and a register. On each accepted symbol it adds the normalization minimum subtracted that step. This equals the growth of the best path metric, i.e. the estimated channel bit errors. It saturates at 16'hFFFF and clears only on reset.
- Undefined: the err_cnt port and its logic are absent. Decoding behaviour is identical.

## Test plan
- All-zero stream: reset, then 40 symbols of 2'b00 back-to-back → out_valid first rises after the 25th accepted symbol; out_bit=0 throughout; err_cnt=0.
- Impulse: info bits 1 then 0×39, fed as symbols 11,11,10,11,00… → first valid out_bit=1, then 0s. Repeat for random 200-bit data through the K=4 encoder model → zero bit mismatches.
- Single error correction: random 200-bit stream with one in_sym bit flipped at symbol 50 → decoded stream error-free; err_cnt=1. Two flips ≥20 symbols apart → err_cnt=2, no decoded errors.
- Valid gaps: same random stream with in_valid deasserted for 1-5 random cycles → identical decoded sequence; out_valid never high during gap-following idle cycles.
- Reset mid-stream: assert rst for 3 cycles at symbol 70, then restart a new encoded stream → out_valid=0 immediately on rst; first valid output after 25 new symbols; output matches the new stream.
- Saturation: with PM_W=5 and a 1000-symbol stream of random noise symbols → no metric wraparound (checked by assertion PM ≤ 31, min PM = 0 every step); err_cnt equals the reference model.
